// File: rtl/gdb_target.sv
// gdb_target: debug-link bridge between a UART (8N1) and a 16-bit Wishbone bus.
// The host sends byte commands over rx_i. The block performs single Wishbone
// reads and writes as a second bus master, and it answers over tx_o.
//
// Commands:
//   'R' a3 a2 a1 a0        -> read  16 bits at address, reply hi, lo
//   'W' a3 a2 a1 a0 d1 d0  -> write 16 bits at address, reply 'K'
//   'S'                    -> reply 'K'
//   other byte             -> reply '?'
//   A bus cycle that gets no ack within ACK_TIMEOUT cycles replies 'E'.
//
// Ports:
//   clk_i     in   clock, all logic on the rising edge
//   rst_i     in   synchronous reset, active low
//   wb_dat_i  in   [15:0] Wishbone read data
//   wb_dat_o  out  [15:0] Wishbone write data
//   wb_adr_o  out  [31:0] Wishbone byte address
//   wb_sel_o  out  [1:0]  byte selects, always 2'b11
//   wb_we_o   out  write enable
//   wb_cyc_o  out  bus cycle active
//   wb_stb_o  out  strobe
//   wb_ack_i  in   slave acknowledge
//   rx_i      in   UART receive, idle high, asynchronous
//   tx_o      out  UART transmit, idle high
module gdb_target #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic [31:0] wb_adr_o,
    output logic [1:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        rx_i,
    output logic        tx_o
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_MID = CW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] TMO_END = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_REPLY} pstate_t;

    logic          rx_meta, rx_sync, rx_prev, rx_busy, rx_valid;
    logic [3:0]    rx_bit;
    logic [CW-1:0] rx_cnt;
    logic [7:0]    rx_shift;

    logic          tx_busy, tx_start;
    logic [3:0]    tx_bits;
    logic [CW-1:0] tx_cnt;
    logic [9:0]    tx_shift;
    logic [7:0]    tx_byte;

    pstate_t       state, state_n;
    logic          is_write, is_write_n;
    logic [1:0]    byte_cnt, byte_cnt_n, reply_len, reply_len_n;
    logic [31:0]   adr, adr_n;
    logic [15:0]   dat, dat_n, reply_buf, reply_buf_n;
    logic          cyc, cyc_n, stb, stb_n, we, we_n;
    logic [TW-1:0] timer, timer_n;

    assign wb_adr_o = adr;
    assign wb_dat_o = dat;
    assign wb_sel_o = 2'b11;
    assign wb_we_o  = we;
    assign wb_cyc_o = cyc;
    assign wb_stb_o = stb;
    assign tx_o     = tx_shift[0];

    // UART receiver. rx_bit 0 is the start bit and is checked at half a bit to
    // reject glitches. Bits 1..8 are data, LSB first. Bit 9 is the stop bit.
    // An edge detector, rather than a level check, starts a frame, so a low
    // stop bit cannot immediately retrigger the receiver.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_busy  <= 1'b0;
            rx_bit   <= 4'd0;
            rx_cnt   <= '0;
            rx_shift <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_meta  <= rx_i;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !rx_sync) begin
                    rx_busy <= 1'b1;
                    rx_bit  <= 4'd0;
                    rx_cnt  <= CW'(1);
                end
            end else if ((rx_bit == 4'd0 && rx_cnt == BIT_MID) ||
                         (rx_bit != 4'd0 && rx_cnt == BIT_END)) begin
                rx_cnt <= CW'(1);
                if (rx_bit == 4'd0) begin
                    if (rx_sync) rx_busy <= 1'b0;
                    else         rx_bit  <= 4'd1;
                end else if (rx_bit <= 4'd8) begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 4'd1;
                end else begin
                    rx_busy  <= 1'b0;
                    rx_valid <= rx_sync;
                end
            end else begin
                rx_cnt <= rx_cnt + CW'(1);
            end
        end
    end

    // UART transmitter. The frame {stop, data, start} is shifted out LSB first.
    // The shift register idles at all ones, which holds the line high.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tx_busy  <= 1'b0;
            tx_bits  <= 4'd0;
            tx_cnt   <= '0;
            tx_shift <= '1;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_busy  <= 1'b1;
                tx_shift <= {1'b1, tx_byte, 1'b0};
                tx_bits  <= 4'd0;
                tx_cnt   <= CW'(1);
            end
        end else if (tx_cnt == BIT_END) begin
            tx_cnt <= CW'(1);
            if (tx_bits == 4'd9) begin
                tx_busy  <= 1'b0;
                tx_shift <= '1;
            end else begin
                tx_shift <= {1'b1, tx_shift[9:1]};
                tx_bits  <= tx_bits + 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + CW'(1);
        end
    end

    // Parser and bus-master state register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= P_IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= 2'd0;
            adr       <= 32'h0;
            dat       <= 16'h0;
            cyc       <= 1'b0;
            stb       <= 1'b0;
            we        <= 1'b0;
            timer     <= '0;
            reply_buf <= 16'h0;
            reply_len <= 2'd0;
        end else begin
            state     <= state_n;
            is_write  <= is_write_n;
            byte_cnt  <= byte_cnt_n;
            adr       <= adr_n;
            dat       <= dat_n;
            cyc       <= cyc_n;
            stb       <= stb_n;
            we        <= we_n;
            timer     <= timer_n;
            reply_buf <= reply_buf_n;
            reply_len <= reply_len_n;
        end
    end

    // Next-state logic. Received bytes are only consumed in IDLE, ADDR and
    // DATA, so anything arriving during BUS or REPLY is dropped. Replies sit
    // in reply_buf with the most significant byte first. reply_len counts
    // the bytes still to hand to the transmitter.
    always_comb begin
        state_n     = state;
        is_write_n  = is_write;
        byte_cnt_n  = byte_cnt;
        adr_n       = adr;
        dat_n       = dat;
        cyc_n       = cyc;
        stb_n       = stb;
        we_n        = we;
        timer_n     = timer;
        reply_buf_n = reply_buf;
        reply_len_n = reply_len;
        tx_start    = 1'b0;
        tx_byte     = reply_buf[15:8];
        case (state)
            P_IDLE: begin
                if (rx_valid) begin
                    byte_cnt_n = 2'd0;
                    case (rx_shift)
                        8'h52: begin state_n = P_ADDR; is_write_n = 1'b0; end
                        8'h57: begin state_n = P_ADDR; is_write_n = 1'b1; end
                        8'h53: begin
                            state_n     = P_REPLY;
                            reply_buf_n = 16'h4B00;
                            reply_len_n = 2'd1;
                        end
                        default: begin
                            state_n     = P_REPLY;
                            reply_buf_n = 16'h3F00;
                            reply_len_n = 2'd1;
                        end
                    endcase
                end
            end
            P_ADDR: begin
                if (rx_valid) begin
                    adr_n      = {adr[23:0], rx_shift};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) state_n = is_write ? P_DATA : P_BUS;
                end
            end
            P_DATA: begin
                if (rx_valid) begin
                    dat_n      = {dat[7:0], rx_shift};
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd1) begin
                        state_n    = P_BUS;
                        byte_cnt_n = 2'd0;
                    end
                end
            end
            P_BUS: begin
                if (!cyc) begin
                    cyc_n   = 1'b1;
                    stb_n   = 1'b1;
                    we_n    = is_write;
                    timer_n = '0;
                end else if (wb_ack_i) begin
                    cyc_n   = 1'b0;
                    stb_n   = 1'b0;
                    we_n    = 1'b0;
                    state_n = P_REPLY;
                    if (is_write) begin
                        reply_buf_n = 16'h4B00;
                        reply_len_n = 2'd1;
                    end else begin
                        reply_buf_n = wb_dat_i;
                        reply_len_n = 2'd2;
                    end
                end else if (timer == TMO_END) begin
                    cyc_n       = 1'b0;
                    stb_n       = 1'b0;
                    we_n        = 1'b0;
                    state_n     = P_REPLY;
                    reply_buf_n = 16'h4500;
                    reply_len_n = 2'd1;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            P_REPLY: begin
                if (!tx_busy) begin
                    if (reply_len != 2'd0) begin
                        tx_start    = 1'b1;
                        reply_buf_n = {reply_buf[7:0], 8'h00};
                        reply_len_n = reply_len - 2'd1;
                    end else begin
                        state_n = P_IDLE;
                    end
                end
            end
            default: state_n = P_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gdb_target.sv
// Self-checking bench for gdb_target.
// Replies are checked through a scoreboard. Each command pushes its expected
// reply bytes, and a UART monitor pops and compares every byte seen on tx_o.
// A Wishbone slave model acknowledges bus cycles with a programmable delay and
// records what the master presented.
module tb_gdb_target;

    localparam int CPB = 16;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [31:0] wb_adr_o;
    logic [1:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
    logic        rx_i;
    logic        tx_o;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    int          tx_seen = 0;

    bit          ack_en = 1'b0;
    int          ack_delay = 0;
    logic [15:0] slave_data = 16'h0;
    int          stb_cnt = 0;
    int          bus_cycles = 0;
    int          last_stb_len = 0;
    int          unstable = 0;
    logic [31:0] cap_adr = 32'h0;
    logic [15:0] cap_dat = 16'h0;
    logic        cap_we = 1'b0;
    logic [1:0]  cap_sel = 2'b00;

    gdb_target #(.CLKS_PER_BIT(CPB), .ACK_TIMEOUT(TMO)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_adr_o (wb_adr_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .rx_i     (rx_i),
        .tx_o     (tx_o)
    );

    always #5 clk = ~clk;

    // Compares one observed value with its expected value and counts the result.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one UART frame on rx_i, with a selectable stop-bit level.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_i = 1'b1;
    endtask

    // Waits, within a cycle budget, until every expected reply byte has been seen.
    task automatic waitReplies(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, exp_q.size(), 0);
        repeat (CPB) @(negedge clk);
    endtask

    // UART monitor. Decodes tx_o at mid-bit and compares each byte with the scoreboard.
    initial begin
        logic [7:0] b;
        logic       stop;
        forever begin
            @(negedge clk);
            if (tx_o === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_o;
                end
                repeat (CPB) @(negedge clk);
                stop = tx_o;
                tx_seen++;
                checkOutput("tx_stop_bit", stop, 1);
                checkOutput("tx_byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) checkOutput("tx_byte", b, exp_q.pop_front());
            end
        end
    end

    // Wishbone slave. It acks after ack_delay strobe cycles and records the
    // request. It also flags any change to the outputs while the strobe is held.
    initial begin
        wb_ack_i = 1'b0;
        wb_dat_i = 16'h0;
        forever begin
            @(negedge clk);
            if (wb_cyc_o && wb_stb_o) begin
                if (stb_cnt == 0) begin
                    bus_cycles++;
                    cap_adr = wb_adr_o;
                    cap_dat = wb_dat_o;
                    cap_we  = wb_we_o;
                    cap_sel = wb_sel_o;
                end else if (wb_adr_o !== cap_adr || wb_dat_o !== cap_dat ||
                             wb_we_o !== cap_we || wb_sel_o !== cap_sel) begin
                    unstable++;
                end
                if (ack_en && stb_cnt >= ack_delay) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = slave_data;
                end
                stb_cnt++;
            end else begin
                if (stb_cnt != 0) last_stb_len = stb_cnt;
                stb_cnt  = 0;
                wb_ack_i = 1'b0;
                wb_dat_i = 16'h0;
            end
        end
    end

    // Directed sequence.
    initial begin
        int n;
        int seen;
        rst_i = 1'b0;
        rx_i  = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rst_tx", tx_o, 1);
        checkOutput("rst_cyc", wb_cyc_o, 0);
        checkOutput("rst_stb", wb_stb_o, 0);
        checkOutput("rst_we", wb_we_o, 0);
        checkOutput("rst_adr", wb_adr_o, 0);
        checkOutput("rst_dat", wb_dat_o, 0);
        checkOutput("rst_sel", wb_sel_o, 2'b11);
        rst_i = 1'b1;
        repeat (4) @(negedge clk);

        // Status command.
        exp_q.push_back(8'h4B);
        applyStimulus(8'h53, 1'b1);
        waitReplies("status_reply", 30 * CPB);

        // Read with a two-cycle ack delay.
        ack_en = 1'b1; ack_delay = 2; slave_data = 16'hA55A;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        applyStimulus(8'h52, 1'b1); applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h10, 1'b1);
        applyStimulus(8'h00, 1'b1);
        waitReplies("read_reply", 40 * CPB);
        checkOutput("read_adr", cap_adr, 32'h0000_1000);
        checkOutput("read_we", cap_we, 0);
        checkOutput("read_sel", cap_sel, 2'b11);
        checkOutput("read_stb_len", last_stb_len, 3);
        checkOutput("read_cycles", bus_cycles, 1);

        // Write acked in the same cycle the strobe rises.
        ack_delay = 0;
        exp_q.push_back(8'h4B);
        applyStimulus(8'h57, 1'b1); applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h10, 1'b1); applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h12, 1'b1);
        applyStimulus(8'h34, 1'b1);
        waitReplies("write_reply", 40 * CPB);
        checkOutput("write_adr", cap_adr, 32'h0010_0000);
        checkOutput("write_dat", cap_dat, 16'h1234);
        checkOutput("write_we", cap_we, 1);
        checkOutput("write_stb_len", last_stb_len, 1);
        checkOutput("write_cycles", bus_cycles, 2);
        checkOutput("write_cyc_low", wb_cyc_o, 0);
        checkOutput("write_stb_low", wb_stb_o, 0);

        // Unknown command byte.
        exp_q.push_back(8'h3F);
        applyStimulus(8'h00, 1'b1);
        waitReplies("unknown_reply", 30 * CPB);

        // Framing error: an 'S' with a low stop bit must be discarded.
        applyStimulus(8'h53, 1'b0);
        repeat (4 * CPB) @(negedge clk);
        exp_q.push_back(8'h4B);
        applyStimulus(8'h53, 1'b1);
        waitReplies("after_framing_reply", 30 * CPB);

        // Quarter-bit glitch on rx_i must be ignored.
        @(negedge clk);
        rx_i = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx_i = 1'b1;
        repeat (15 * CPB) @(negedge clk);
        exp_q.push_back(8'h4B);
        applyStimulus(8'h53, 1'b1);
        waitReplies("after_glitch_reply", 30 * CPB);

        // Read timeout with no ack.
        ack_en = 1'b0;
        exp_q.push_back(8'h45);
        applyStimulus(8'h52, 1'b1); applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'hFF, 1'b1); applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'hF0, 1'b1);
        waitReplies("timeout_reply", TMO + 40 * CPB);
        checkOutput("timeout_adr", cap_adr, 32'hFFFF_FFF0);
        checkOutput("timeout_stb_len", last_stb_len, TMO);
        checkOutput("timeout_cyc_low", wb_cyc_o, 0);
        checkOutput("timeout_cycles", bus_cycles, 3);

        // Reset while the bus cycle is in progress.
        applyStimulus(8'h52, 1'b1); applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1); applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h04, 1'b1);
        n = 0;
        while (wb_stb_o !== 1'b1 && n < 40 * CPB) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bus_reached", wb_stb_o, 1);
        rst_i = 1'b0;
        @(negedge clk);
        checkOutput("midbus_rst_cyc", wb_cyc_o, 0);
        checkOutput("midbus_rst_stb", wb_stb_o, 0);
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        seen = tx_seen;
        repeat (TMO + 15 * CPB) @(negedge clk);
        checkOutput("midbus_rst_no_tx", tx_seen, seen);
        checkOutput("midbus_rst_tx_idle", tx_o, 1);

        // The block must still answer after that reset.
        exp_q.push_back(8'h4B);
        applyStimulus(8'h53, 1'b1);
        waitReplies("alive_reply", 30 * CPB);

        checkOutput("bus_outputs_stable", unstable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
